// File: rtl/product_accumulator.sv
// Sums a sequence of 8-bit products into an ACC_W-bit result with a saturating beat count and sticky wrap flag.
// Latency: result is presented one clock after the beat carrying in_last is accepted.
// Backpressure: in_ready drops while a result is held; the result stays put until out_ready is sampled high.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int SUM_W = ACC_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    logic             accept;
    logic [SUM_W-1:0] sum_ext;
    logic             cnt_full;

    // Handshake and outputs decode from registered state only, so no input reaches an output combinationally.
    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_count = out_valid ? cnt_q : '0;
    assign out_ovf   = out_valid ? ovf_q : 1'b0;

    assign accept   = in_valid && in_ready;
    // One extra bit on the adder exposes the carry out used for the sticky wrap flag.
    assign sum_ext  = {1'b0, acc_q} + SUM_W'(in_prod);
    assign cnt_full = (cnt_q == {CNT_W{1'b1}});

    // Next-state and datapath update: first beat loads, later beats accumulate, HOLD waits for the consumer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(in_prod);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    cnt_d   = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d   = ovf_q | sum_ext[ACC_W];
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any handshake and drops any partial or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: vector table plus hand-written long-sequence checks.
// Each vector is driven for one clock; outputs are compared 1 time unit after the rising edge.
// Expected values are hand-computed constants.
module tb_product_accumulator;

    localparam int ACC_W = 12;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int errors = 0;
    int checks = 0;

    product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] prod;
        logic       last;
        logic       ordy;
        logic       e_rdy;
        logic       e_vld;
        int         e_sum;
        int         e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic v, input int p, input logic l, input logic o,
                       input logic er, input logic ev, input int es, input int ec, input logic eo);
        vec_t t;
        t.rst = r; t.vld = v; t.prod = 8'(p); t.last = l; t.ordy = o;
        t.e_rdy = er; t.e_vld = ev; t.e_sum = es; t.e_cnt = ec; t.e_ovf = eo;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_step(input logic r, input logic v, input int p, input logic l, input logic o);
        rst       = r;
        in_valid  = v;
        in_prod   = 8'(p);
        in_last   = l;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic er, input logic ev, input int es,
                              input int ec, input logic eo);
        check($sformatf("%s in_ready", tag),  int'(in_ready),  int'(er));
        check($sformatf("%s out_valid", tag), int'(out_valid), int'(ev));
        check($sformatf("%s out_sum", tag),   int'(out_sum),   es);
        check($sformatf("%s out_count", tag), int'(out_count), ec);
        check($sformatf("%s out_ovf", tag),   int'(out_ovf),   int'(eo));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_prod = 8'd0; in_last = 1'b0; out_ready = 1'b0;

        //   rst vld prod last ordy | rdy vld sum cnt ovf
        // reset and idle
        add(1, 0,   0, 0, 0,   1, 0,   0, 0, 0);
        add(0, 0,   0, 0, 0,   1, 0,   0, 0, 0);
        // single beat of 225
        add(0, 1, 225, 1, 0,   0, 1, 225, 1, 0);
        add(0, 0,   0, 0, 1,   1, 0,   0, 0, 0);
        // 10, 20, 30 with bubbles carrying junk data
        add(0, 1,  10, 0, 0,   1, 0,   0, 0, 0);
        add(0, 0,  99, 0, 0,   1, 0,   0, 0, 0);
        add(0, 1,  20, 0, 0,   1, 0,   0, 0, 0);
        add(0, 0,  55, 1, 1,   1, 0,   0, 0, 0);
        add(0, 1,  30, 1, 0,   0, 1,  60, 3, 0);
        // backpressure: five held cycles with in_valid high, then consume
        for (int i = 0; i < 5; i++) add(0, 1, 7, 1, 0,   0, 1, 60, 3, 0);
        add(0, 1,   7, 1, 1,   1, 0,   0, 0, 0);
        // reset mid-sequence, asserted together with in_valid and out_ready
        add(0, 1,  50, 0, 0,   1, 0,   0, 0, 0);
        add(0, 1,  60, 0, 0,   1, 0,   0, 0, 0);
        add(1, 1,  70, 1, 1,   1, 0,   0, 0, 0);
        add(0, 1,   5, 1, 0,   0, 1,   5, 1, 0);
        // back-to-back: consume on first HOLD cycle, then beat 9
        add(0, 0,   0, 0, 1,   1, 0,   0, 0, 0);
        add(0, 1,   9, 1, 0,   0, 1,   9, 1, 0);
        add(0, 0,   0, 0, 1,   1, 0,   0, 0, 0);
        // reset while holding a result: it must never appear
        add(0, 1, 100, 1, 0,   0, 1, 100, 1, 0);
        add(1, 0,   0, 0, 0,   1, 0,   0, 0, 0);
        add(0, 0,   0, 0, 1,   1, 0,   0, 0, 0);
        add(0, 0,   0, 0, 0,   1, 0,   0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            drive_step(vq[i].rst, vq[i].vld, vq[i].prod, vq[i].last, vq[i].ordy);
            check_outs($sformatf("vec%0d", i), vq[i].e_rdy, vq[i].e_vld, vq[i].e_sum,
                       vq[i].e_cnt, vq[i].e_ovf);
        end

        // 19 beats of 225: sum 4275 wraps to 179, count saturates at 15, ovf sticks
        for (int b = 1; b <= 18; b++) begin
            drive_step(0, 1, 225, 0, 0);
            check($sformatf("long beat%0d in_ready", b), int'(in_ready), 1);
            check($sformatf("long beat%0d out_valid", b), int'(out_valid), 0);
        end
        drive_step(0, 1, 225, 1, 0);
        check_outs("long result", 1'b0, 1'b1, 179, 15, 1'b1);
        drive_step(0, 0, 0, 0, 0);
        check_outs("long held", 1'b0, 1'b1, 179, 15, 1'b1);
        drive_step(0, 0, 0, 0, 1);
        check_outs("long consumed", 1'b1, 1'b0, 0, 0, 1'b0);

        // ovf and count must restart on the next sequence
        drive_step(0, 1, 1, 1, 0);
        check_outs("after long", 1'b0, 1'b1, 1, 1, 1'b0);
        drive_step(0, 0, 0, 0, 1);
        check_outs("after long consumed", 1'b1, 1'b0, 0, 0, 1'b0);

        // 15 beats reach the count ceiling exactly without wrapping (15*200 = 3000)
        for (int b = 1; b <= 14; b++) drive_step(0, 1, 200, 0, 0);
        drive_step(0, 1, 200, 1, 0);
        check_outs("cnt15", 1'b0, 1'b1, 3000, 15, 1'b0);
        drive_step(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 12, giving the accumulator and result width in bits (minimum 8).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the beat-counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_prod and in_last are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a product this cycle.
REQ-007 The block SHALL have port in_prod, input, 8 bits: unsigned 4x4 multiplier product, 0..225.
REQ-008 The block SHALL have port in_last, input, 1 bit: the accepted beat is the final product of a sequence.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result fields are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port out_sum, output, ACC_W bits: the sum of the sequence, modulo 2^ACC_W.
REQ-012 The block SHALL have port out_count, output, CNT_W bits: the number of beats in the sequence, saturating.
REQ-013 The block SHALL have port out_ovf, output, 1 bit: the sum wrapped at least once during the sequence.

Function
REQ-014 The block SHALL implement three states: IDLE (no beats yet), ACCUM (partial sum held), and HOLD (result presented).
REQ-015 The block SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = 0 in HOLD; in_ready SHALL be a registered-state decode only.
REQ-016 A beat SHALL be accepted only on a cycle with in_valid = 1 and in_ready = 1; other cycles SHALL leave acc, count and ovf unchanged.
REQ-017 On an accepted beat in IDLE, the block SHALL load acc = in_prod (zero-extended), count = 1, and ovf = 0.
REQ-018 On an accepted beat in ACCUM, the block SHALL set acc = acc + in_prod modulo 2^ACC_W.
REQ-019 On an accepted beat in ACCUM, count SHALL increment and saturate at 2^CNT_W-1.
REQ-020 On an accepted beat in ACCUM, ovf SHALL be set sticky if the (ACC_W+1)-bit sum has its MSB set.
REQ-021 After an accepted beat with in_last = 0, the next state SHALL be ACCUM.
REQ-022 After an accepted beat with in_last = 1, the next state SHALL be HOLD, including a single-beat sequence accepted from IDLE.
REQ-023 out_valid SHALL be 1 exactly while in HOLD; latency from acceptance of the last beat to out_valid = 1 SHALL be one clock.
REQ-024 In HOLD, out_sum, out_count and out_ovf SHALL be stable until out_ready = 1 is sampled.
REQ-025 In HOLD with out_ready = 1, the next state SHALL be IDLE; with out_ready = 0, the block SHALL remain in HOLD indefinitely.
REQ-026 Outside HOLD, out_sum, out_count and out_ovf SHALL read 0.
REQ-027 in_valid asserted while in HOLD SHALL be ignored, with no accept and no state change.
REQ-028 The block SHALL have no combinational path from in_valid/in_prod/in_last/out_ready to any output.

Reset
REQ-029 While rst = 1 at a rising edge, the next state SHALL be IDLE, acc = 0, count = 0, and ovf = 0, regardless of state or handshake inputs.
REQ-030 In the cycle after reset, the outputs SHALL be in_ready = 1, out_valid = 0, out_sum = 0, out_count = 0, and out_ovf = 0.
REQ-031 Reset during ACCUM or HOLD SHALL discard the partial or pending result; no result for that sequence SHALL ever appear.
REQ-032 rst SHALL take priority over simultaneous in_valid or out_ready.

Verification
REQ-033 The bench SHALL check a single beat: in_prod = 225, in_last = 1 -> next cycle out_valid = 1, out_sum = 225, out_count = 1, out_ovf = 0.
REQ-034 The bench SHALL check beats 10, 20, 30 with in_last on the third and idle cycles between beats -> out_sum = 60, out_count = 3, out_ovf = 0; bubbles SHALL NOT alter the sum.
REQ-035 The bench SHALL check 19 beats of 225 with ACC_W = 12 and CNT_W = 4 -> out_sum = 179 (4275 mod 4096), out_count = 15, out_ovf = 1.
REQ-036 The bench SHALL check backpressure: out_ready = 0 for 5 cycles in HOLD while in_valid = 1 with in_prod = 7 -> out_valid stays 1, outputs unchanged, in_ready = 0; out_ready = 1 -> IDLE next cycle, out_valid = 0.
REQ-037 The bench SHALL check reset mid-sequence: after beats 50 and 60 without in_last, pulse rst for one cycle, then send beat 5 with in_last -> out_sum = 5, out_count = 1.
REQ-038 The bench SHALL check back-to-back sequences: result consumed with out_ready = 1 on its first HOLD cycle, then beat 9 with in_last on the next cycle -> second result out_sum = 9, with no carry-over from the first sequence.
